// File: rtl/cache_port_arbiter_if.sv
// Requester-side and cache-side signal bundle for cache_port_arbiter.
// The arbiter connects through the slave modport; requesters and the cache model drive the master modport.
interface cache_port_arbiter_if #(
  parameter int NUM_REQ         = 2,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int CACHE_LINE_SIZE = 32
);
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STRB_W = CACHE_LINE_SIZE / 8;

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   req_address;
  logic [NUM_REQ*CACHE_LINE_SIZE-1:0] req_data;
  logic [NUM_REQ*STRB_W-1:0]          req_strobe;
  logic [NUM_REQ-1:0]                 req_wen;
  logic [NUM_REQ-1:0]                 resp_valid;
  logic [NUM_REQ-1:0]                 resp_error;
  logic [CACHE_LINE_SIZE-1:0]         resp_data;
  logic [ID_W-1:0]                    grant_id;
  logic                               busy;

  logic                               reqValid_CPU;
  logic [ADDRESS_WIDTH-1:0]           address_in_CPU;
  logic [CACHE_LINE_SIZE-1:0]         data_in_CPU;
  logic [STRB_W-1:0]                  strobe_CPU;
  logic                               wen_CPU;
  logic [CACHE_LINE_SIZE-1:0]         data_out_CPU;
  logic                               hit_CPU;

  modport master (
    output req_valid, req_address, req_data, req_strobe, req_wen,
    output data_out_CPU, hit_CPU,
    input  resp_valid, resp_error, resp_data, grant_id, busy,
    input  reqValid_CPU, address_in_CPU, data_in_CPU, strobe_CPU, wen_CPU
  );

  modport slave (
    input  req_valid, req_address, req_data, req_strobe, req_wen,
    input  data_out_CPU, hit_CPU,
    output resp_valid, resp_error, resp_data, grant_id, busy,
    output reqValid_CPU, address_in_CPU, data_in_CPU, strobe_CPU, wen_CPU
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing the single CPU-side cache port among NUM_REQ requesters.
// Optional BUSY timeout enabled by defining ARB_TIMEOUT_EN.
module cache_port_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int CACHE_LINE_SIZE = 32,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_port_arbiter_if.slave  bus
);
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STRB_W = CACHE_LINE_SIZE / 8;

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("cache_port_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                     state, state_nxt;
  logic [ID_W-1:0]            rr_ptr;
  logic [ID_W-1:0]            grant;
  logic [ID_W-1:0]            win_id;
  logic [ID_W-1:0]            scan_idx;
  logic                       win_found;
  logic                       grant_en;
  logic                       capture_en;
  logic                       tmo_limit;
  logic                       tmo_fire;

  logic [ADDRESS_WIDTH-1:0]   addr_q;
  logic [CACHE_LINE_SIZE-1:0] wdata_q;
  logic [STRB_W-1:0]          strb_q;
  logic                       wen_q;
  logic [CACHE_LINE_SIZE-1:0] rdata_q;
  logic [NUM_REQ-1:0]         resp_valid_c;
  logic [NUM_REQ-1:0]         resp_error_c;

  // First asserted request scanning from rr_ptr upward, wrapping modulo NUM_REQ
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_found && bus.req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_en   = 1'b0;
    capture_en = 1'b0;
    tmo_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          grant_en  = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // A hit landing on the same cycle as the limit takes priority
        if (bus.hit_CPU) begin
          capture_en = 1'b1;
          state_nxt  = RESP;
        end else if (tmo_limit) begin
          tmo_fire  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Latched request and returned line; held stable for the whole access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      grant   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      wen_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (grant_en) begin
        grant   <= win_id;
        rr_ptr  <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
        addr_q  <= bus.req_address[int'(win_id)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        wdata_q <= bus.req_data[int'(win_id)*CACHE_LINE_SIZE +: CACHE_LINE_SIZE];
        strb_q  <= bus.req_strobe[int'(win_id)*STRB_W +: STRB_W];
        wen_q   <= bus.req_wen[win_id];
      end
      if (capture_en) begin
        rdata_q <= bus.data_out_CPU;
      end else if (tmo_fire) begin
        rdata_q <= '0;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  // tmo_cnt counts completed hit-less BUSY cycles; the limit trips on the last one
  assign tmo_limit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (grant_en) begin
        tmo_cnt <= '0;
        err_q   <= 1'b0;
      end else if (state == BUSY && !bus.hit_CPU) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (tmo_fire) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    resp_error_c = '0;
    if (state == RESP) begin
      resp_error_c[grant] = err_q;
    end
  end
`else
  assign tmo_limit    = 1'b0;
  assign resp_error_c = '0;
`endif

  always_comb begin
    resp_valid_c = '0;
    if (state == RESP) begin
      resp_valid_c[grant] = 1'b1;
    end
  end

  assign bus.resp_valid     = resp_valid_c;
  assign bus.resp_error     = resp_error_c;
  assign bus.resp_data      = rdata_q;
  assign bus.grant_id       = grant;
  assign bus.busy           = (state != IDLE);
  assign bus.reqValid_CPU   = (state == BUSY);
  assign bus.address_in_CPU = addr_q;
  assign bus.data_in_CPU    = wdata_q;
  assign bus.strobe_CPU     = strb_q;
  assign bus.wen_CPU        = wen_q;
endmodule
